// File: rtl/key_step_controller_if.sv
// ---------------------------------------------------------------------------
// key_step_controller_if
//
// Groups the operator-facing inputs and processor-facing outputs of the
// single-step / auto-run clock controller.
//
//   key_n       raw pushbutton, asynchronous, 0 = pressed
//   run_mode    slide switch, asynchronous, 1 = auto-run, 0 = single-step
//   halt        synchronous stop request, 1 blocks the start of new steps
//   step_clk    registered step clock for the processor
//   step_pulse  one-cycle strobe at the start of each step
//   pressed     debounced key level, 1 = held
//   step_count  number of steps issued, wraps modulo 2^16
//
// Modports: slave = the controller, master = whatever drives the controls.
// ---------------------------------------------------------------------------
interface key_step_controller_if;
   logic        key_n;
   logic        run_mode;
   logic        halt;
   logic        step_clk;
   logic        step_pulse;
   logic        pressed;
   logic [15:0] step_count;

   modport slave (
      input  key_n,
      input  run_mode,
      input  halt,
      output step_clk,
      output step_pulse,
      output pressed,
      output step_count
   );

   modport master (
      output key_n,
      output run_mode,
      output halt,
      input  step_clk,
      input  step_pulse,
      input  pressed,
      input  step_count
   );
endinterface

// File: rtl/key_step_controller.sv
// ---------------------------------------------------------------------------
// key_step_controller
//
// Turns a bouncy pushbutton into clean processor step clocks. In single-step
// mode each accepted press produces one step (one high phase followed by one
// low phase of step_clk). In auto-run mode a press starts a free-running
// sequence of steps separated by a programmable wait; the sequence stops as
// soon as the run switch returns to single-step.
//
// Ports:
//   clk    50 MHz system clock, rising-edge
//   rst_n  asynchronous active-low reset
//   bus    key_step_controller_if.slave (key_n, run_mode, halt in;
//          step_clk, step_pulse, pressed, step_count out)
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles a key level change must persist to be accepted
//   PULSE_CYCLES     width of each step_clk high phase and low phase
//   RUN_DIV          cycles spent waiting between auto-run steps
// ---------------------------------------------------------------------------
module key_step_controller #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int PULSE_CYCLES    = 4,
   parameter int RUN_DIV         = 25000000
) (
   input logic                    clk,
   input logic                    rst_n,
   key_step_controller_if.slave   bus
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int PC_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
   localparam int DV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

   typedef enum logic [1:0] {
      IDLE,
      HIGH,
      LOW,
      RUN_WAIT
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic              key_sync1;
   logic              key_sync2;
   logic              run_sync1;
   logic              run_sync2;

   logic [DB_W-1:0]   db_cnt;
   logic              pressed_q;
   logic              pressed_d;
   logic              press_event;
   logic              key_level;

   logic [PC_W-1:0]   pulse_cnt;
   logic              pulse_last;
   logic [DV_W-1:0]   div_cnt;
   logic              div_last;

   logic              step_clk_q;
   logic              step_pulse_q;
   logic [15:0]       step_count_q;
   logic              step_clk_nxt;
   logic              step_pulse_nxt;
   logic [15:0]       step_count_nxt;

   // Two-flop synchronizers for the asynchronous operator inputs. The key
   // chain idles at 1 (released) and the run chain at 0 (single-step) so
   // that reset never looks like a press or an auto-run request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_sync1 <= 1'b1;
         key_sync2 <= 1'b1;
         run_sync1 <= 1'b0;
         run_sync2 <= 1'b0;
      end else begin
         key_sync1 <= bus.key_n;
         key_sync2 <= key_sync1;
         run_sync1 <= bus.run_mode;
         run_sync2 <= run_sync1;
      end
   end

   // key_level is the synchronized key in "1 = held" sense, directly
   // comparable with the debounced level.
   assign key_level = ~key_sync2;

   // Debouncer: the counter measures how long the synchronized level has
   // disagreed with the accepted level. Any agreement restarts the count,
   // so only an uninterrupted disagreement of DEBOUNCE_CYCLES flips it.
   // pressed_d remembers the previous accepted level for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_cnt    <= '0;
         pressed_q <= 1'b0;
         pressed_d <= 1'b0;
      end else begin
         pressed_d <= pressed_q;
         if (key_level == pressed_q) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt    <= '0;
            pressed_q <= ~pressed_q;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
      end
   end

   // A press is the one cycle where the accepted level has just become 1.
   assign press_event = pressed_q & ~pressed_d;

   assign pulse_last = (pulse_cnt == PC_W'(PULSE_CYCLES - 1));
   assign div_last   = (div_cnt == DV_W'(RUN_DIV - 1));

   // State register plus the registered outputs, so step_clk, step_pulse
   // and pressed all come straight from flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         step_clk_q   <= 1'b0;
         step_pulse_q <= 1'b0;
         step_count_q <= '0;
      end else begin
         state        <= state_nxt;
         step_clk_q   <= step_clk_nxt;
         step_pulse_q <= step_pulse_nxt;
         step_count_q <= step_count_nxt;
      end
   end

   // Next-state logic. Presses are only acted on in IDLE, so anything that
   // arrives mid-step or during the auto-run wait is simply dropped. Halt
   // only gates entry into HIGH; once a step has begun it always finishes.
   // A run-mode change is looked at in LOW only when the low phase ends.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (press_event) begin
               if (run_sync2) begin
                  state_nxt = RUN_WAIT;
               end else if (!bus.halt) begin
                  state_nxt = HIGH;
               end
            end
         end
         HIGH: begin
            if (pulse_last) begin
               state_nxt = LOW;
            end
         end
         LOW: begin
            if (pulse_last) begin
               state_nxt = run_sync2 ? RUN_WAIT : IDLE;
            end
         end
         RUN_WAIT: begin
            if (!run_sync2) begin
               state_nxt = IDLE;
            end else if (!bus.halt && div_last) begin
               state_nxt = HIGH;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Phase and wait counters. Both restart on every state change, which
   // also gives the "divider cleared" behaviour on entry to RUN_WAIT. The
   // divider freezes while halted so the wait resumes where it stopped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pulse_cnt <= '0;
         div_cnt   <= '0;
      end else begin
         if (state_nxt != state) begin
            pulse_cnt <= '0;
         end else if (state == HIGH || state == LOW) begin
            pulse_cnt <= pulse_cnt + PC_W'(1);
         end

         if (state != RUN_WAIT || state_nxt != RUN_WAIT) begin
            div_cnt <= '0;
         end else if (!bus.halt) begin
            div_cnt <= div_cnt + DV_W'(1);
         end
      end
   end

   // Output logic, computed from the upcoming state so the registered
   // outputs line up with the state they describe. The step strobe and
   // the count bump happen together on the edge that enters HIGH.
   always_comb begin
      step_clk_nxt   = 1'b0;
      step_pulse_nxt = 1'b0;
      step_count_nxt = step_count_q;
      if (state_nxt == HIGH) begin
         step_clk_nxt = 1'b1;
         if (state != HIGH) begin
            step_pulse_nxt = 1'b1;
            step_count_nxt = step_count_q + 16'd1;
         end
      end
   end

   assign bus.step_clk   = step_clk_q;
   assign bus.step_pulse = step_pulse_q;
   assign bus.pressed    = pressed_q;
   assign bus.step_count = step_count_q;

endmodule

// File: tb/tb_key_step_controller.sv
// ---------------------------------------------------------------------------
// tb_key_step_controller
//
// Directed bench for key_step_controller with small timing parameters
// (debounce 8, pulse phase 2, run divider 10). A table of input/expected
// records covers debouncing, single steps, halt and a key held through
// reset; hand-written sequences cover auto-run spacing and reset mid-pulse.
// Inputs change on falling edges and outputs are sampled on falling edges.
// ---------------------------------------------------------------------------
module tb_key_step_controller;

   localparam int DB = 8;
   localparam int PC = 2;
   localparam int RD = 10;

   typedef struct {
      logic        rst;
      logic        key_n;
      logic        run_mode;
      logic        halt;
      int          cycles;
      logic        exp_pressed;
      logic        exp_clk;
      logic        exp_pulse;
      logic [15:0] exp_count;
   } vec_t;

   logic clk;
   logic rst_n;

   key_step_controller_if bus ();

   key_step_controller #(
      .DEBOUNCE_CYCLES (DB),
      .PULSE_CYCLES    (PC),
      .RUN_DIV         (RD)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   checks;
   int   errors;
   vec_t vecs[$];

   int   pulse_n;
   int   first_pulse;
   int   last_pulse;
   int   clk_seen;

   // 100 MHz-ish bench clock; only cycle counts matter here.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Guard against any hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
      end
   endtask

   task automatic resetDut();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic applyStimulus(input vec_t v);
      bus.key_n    = v.key_n;
      bus.run_mode = v.run_mode;
      bus.halt     = v.halt;
      if (v.rst) resetDut();
      repeat (v.cycles) @(negedge clk);
   endtask

   task automatic addVec(input logic rst, input logic k, input logic r, input logic h,
                         input int cyc, input logic p, input logic c, input logic s,
                         input logic [15:0] n);
      vec_t v;
      v.rst         = rst;
      v.key_n       = k;
      v.run_mode    = r;
      v.halt        = h;
      v.cycles      = cyc;
      v.exp_pressed = p;
      v.exp_clk     = c;
      v.exp_pulse   = s;
      v.exp_count   = n;
      vecs.push_back(v);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n        = 1'b0;
      bus.key_n    = 1'b1;
      bus.run_mode = 1'b0;
      bus.halt     = 1'b0;

      // Clean single-step press, key drops at N0: pressed at N10, step at N11.
      //      rst  key run halt cyc  prs clk pls cnt
      addVec(1,   1,  0,  0,   2,   0,  0,  0,  0);
      addVec(0,   0,  0,  0,   9,   0,  0,  0,  0);
      addVec(0,   0,  0,  0,   1,   1,  0,  0,  0);
      addVec(0,   0,  0,  0,   1,   1,  1,  1,  1);
      addVec(0,   0,  0,  0,   1,   1,  1,  0,  1);
      addVec(0,   0,  0,  0,   1,   1,  0,  0,  1);
      addVec(0,   0,  0,  0,   7,   1,  0,  0,  1);
      addVec(0,   1,  0,  0,   9,   1,  0,  0,  1);
      addVec(0,   1,  0,  0,   1,   0,  0,  0,  1);
      addVec(0,   1,  0,  0,  12,   0,  0,  0,  1);
      // Five short glitches must never be accepted.
      addVec(1,   1,  0,  0,   2,   0,  0,  0,  0);
      for (int g = 0; g < 5; g++) begin
         addVec(0, 0, 0, 0, 3, 0, 0, 0, 0);
         addVec(0, 1, 0, 0, 3, 0, 0, 0, 0);
      end
      addVec(0,   1,  0,  0,  12,   0,  0,  0,  0);
      // Halted press is dropped; a later unhalted press steps.
      addVec(1,   1,  0,  1,   2,   0,  0,  0,  0);
      addVec(0,   0,  0,  1,  10,   1,  0,  0,  0);
      addVec(0,   0,  0,  1,   1,   1,  0,  0,  0);
      addVec(0,   0,  0,  1,   5,   1,  0,  0,  0);
      addVec(0,   1,  0,  1,  10,   0,  0,  0,  0);
      addVec(0,   0,  0,  0,  10,   1,  0,  0,  0);
      addVec(0,   0,  0,  0,   1,   1,  1,  1,  1);
      addVec(0,   0,  0,  0,   3,   1,  0,  0,  1);
      // Key held through reset release: press DB+2 edges after release.
      addVec(1,   0,  0,  0,   9,   0,  0,  0,  0);
      addVec(0,   0,  0,  0,   1,   1,  0,  0,  0);
      addVec(0,   0,  0,  0,   1,   1,  1,  1,  1);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d pressed", i), int'(bus.pressed), int'(vecs[i].exp_pressed));
         checkOutput($sformatf("vec%0d step_clk", i), int'(bus.step_clk), int'(vecs[i].exp_clk));
         checkOutput($sformatf("vec%0d step_pulse", i), int'(bus.step_pulse), int'(vecs[i].exp_pulse));
         checkOutput($sformatf("vec%0d step_count", i), int'(bus.step_count), int'(vecs[i].exp_count));
      end

      // Auto-run: first step at N21, then every 14 cycles; dropping run
      // mode at N100 (inside RUN_WAIT) stops before the step due at N105.
      bus.key_n    = 1'b1;
      bus.run_mode = 1'b1;
      bus.halt     = 1'b0;
      resetDut();
      bus.key_n   = 1'b0;
      pulse_n     = 0;
      first_pulse = -1;
      last_pulse  = 0;
      for (int i = 1; i <= 130; i++) begin
         @(negedge clk);
         if (bus.step_pulse) begin
            pulse_n++;
            if (first_pulse < 0) first_pulse = i;
            else checkOutput("autorun interval", i - last_pulse, PC + PC + RD);
            last_pulse = i;
         end
         if (i == 100) begin
            bus.key_n    = 1'b1;
            bus.run_mode = 1'b0;
         end
      end
      checkOutput("autorun first pulse", first_pulse, 21);
      checkOutput("autorun pulse count", pulse_n, 6);
      checkOutput("autorun step_count", int'(bus.step_count), 6);

      // Reset in the second HIGH cycle aborts the step immediately.
      bus.key_n    = 1'b1;
      bus.run_mode = 1'b0;
      resetDut();
      bus.key_n = 1'b0;
      repeat (11) @(negedge clk);
      checkOutput("midreset pre step_clk", int'(bus.step_clk), 1);
      checkOutput("midreset pre step_count", int'(bus.step_count), 1);
      @(posedge clk);
      #2;
      rst_n     = 1'b0;
      bus.key_n = 1'b1;
      #1;
      checkOutput("midreset step_clk", int'(bus.step_clk), 0);
      checkOutput("midreset step_count", int'(bus.step_count), 0);
      checkOutput("midreset step_pulse", int'(bus.step_pulse), 0);
      checkOutput("midreset pressed", int'(bus.pressed), 0);
      repeat (2) @(negedge clk);
      rst_n    = 1'b1;
      clk_seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.step_clk || bus.step_pulse) clk_seen++;
      end
      checkOutput("post reset step activity", clk_seen, 0);
      checkOutput("post reset step_count", int'(bus.step_count), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/key_step_controller.md
KEY_STEP_CONTROLLER -- requirements
Module: key_step_controller

Interface
REQ-001 DEBOUNCE_CYCLES, 500000, consecutive cycles a key level change must persist before acceptance (10 ms at 50 MHz).
REQ-002 PULSE_CYCLES, 4, width in cycles of each StepClk high phase and each low phase.
REQ-003 RUN_DIV, 25000000, cycles spent in RUN_WAIT between auto-run steps.
REQ-004 Clock  input  1  50 MHz system clock; all state updates on the rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 KeyN  input  1  raw pushbutton, asynchronous; 0 = pressed.
REQ-007 RunMode  input  1  slide switch, asynchronous; 1 = auto-run, 0 = single-step.
REQ-008 Halt  input  1  synchronous to Clock; 1 blocks the start of new steps.
REQ-009 StepClk  output  1  registered step clock for the processor.
REQ-010 StepPulse  output  1  one-cycle strobe marking the start of each step.
REQ-011 Pressed  output  1  debounced key level; 1 = held.
REQ-012 StepCount  output  16  number of steps issued; modulo 2^16.

Function
REQ-013 KeyN and RunMode each pass through a two-flop synchronizer; only the synchronized values are used internally.
REQ-014 Debounce counter clears whenever the synchronized key level equals Pressed and increments otherwise.
REQ-015 When the counter reaches DEBOUNCE_CYCLES-1 with the level still differing, Pressed toggles on the next edge and the counter clears; any excursion shorter than DEBOUNCE_CYCLES leaves Pressed unchanged.
REQ-016 A press event is the single cycle in which Pressed goes 0->1; release generates no event.
REQ-017 FSM states: IDLE, HIGH, LOW, RUN_WAIT.
REQ-018 IDLE: on a press event with Halt=0 and synchronized RunMode=0 -> HIGH; with synchronized RunMode=1 -> RUN_WAIT, divider cleared.
REQ-019 HIGH: StepClk=1 for exactly PULSE_CYCLES cycles, then -> LOW.
REQ-020 LOW: StepClk=0 for exactly PULSE_CYCLES cycles, then -> RUN_WAIT (divider cleared) if synchronized RunMode=1, else -> IDLE.
REQ-021 RUN_WAIT: divider increments each cycle with Halt=0 and holds with Halt=1; at RUN_DIV-1 with Halt=0 -> HIGH; synchronized RunMode=0 -> IDLE immediately.
REQ-022 StepPulse=1 and StepCount increments in the first HIGH cycle only; StepCount wraps FFFF->0000.
REQ-023 Single-step latency: StepClk rises on the edge following the one on which Pressed rises.
REQ-024 Press events arriving in HIGH, LOW or RUN_WAIT are discarded, never queued.
REQ-025 Halt is evaluated only on entry to HIGH; a pulse already in progress always completes both phases.
REQ-026 RunMode changes during HIGH/LOW take effect only at the end of LOW.
REQ-027 StepClk, StepPulse and Pressed are driven directly from flops, glitch-free.

Reset
REQ-028 Reset=0 forces immediately: state IDLE, StepClk=0, StepPulse=0, Pressed=0, StepCount=0, all counters 0, key synchronizer flops 1, RunMode synchronizer flops 0.
REQ-029 Reset asserted mid-pulse aborts the pulse with no partial count retained.
REQ-030 A key held through reset release yields exactly one press event, DEBOUNCE_CYCLES+2 cycles after release.

Verification (DEBOUNCE_CYCLES=8, PULSE_CYCLES=2, RUN_DIV=10)
REQ-031 KeyN low 20 cycles, RunMode=0 -> Pressed rises once, one StepPulse, StepClk high exactly 2 cycles, StepCount=1.
REQ-032 KeyN five 3-cycle low glitches separated by 3 high cycles -> Pressed stays 0, StepClk stays 0, StepCount=0.
REQ-033 Halt=1 during a clean press -> Pressed rises, no StepPulse, StepCount stays 0; a second press with Halt=0 -> StepCount=1.
REQ-034 RunMode=1 then one press, held 100 cycles -> StepPulse strobes exactly 14 cycles apart; RunMode=0 in RUN_WAIT -> no further steps.
REQ-035 Reset=0 on the second HIGH cycle -> StepClk=0 and StepCount=0 in the same cycle; after release with key idle, no step occurs.
